sfm_slot_regfile: RTL and testbench
===================================

Name: sfm_slot_regfile

Overview:
- Storage for the per-row softmax state slots (running maximum, running denominator, valid bit) used by the controller when it spans rows across multiple jobs.
- Sits directly downstream of the controller's slot-control outputs (request op ALLOC/LOAD, update op UPDATE/FREE).
- Returns slot contents to the controller, which forwards them to the datapath as the load_max/load_denominator values.

Parameters:
- N_SLOTS, 8, number of slots (2..2^ADDR_W).
- ADDR_W, 8, slot address width (= SLOT_ADDR_BITS).
- WIDTH_IN, 16, maximum field width (FP16ALT).
- WIDTH_ACC, 32, denominator field width (FP32).
- MAX_INIT, 16'hFF80, maximum value written on ALLOC (FP16ALT -inf).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  invalidate all slots.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  1  0=ALLOC, 1=LOAD.
- req_addr_i  in  ADDR_W  LOAD address (ignored for ALLOC).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_addr_o  out  ADDR_W  allocated or loaded slot address.
- rsp_max_o  out  WIDTH_IN  slot maximum.
- rsp_den_o  out  WIDTH_ACC  slot denominator.
- rsp_err_o  out  1  request failed.
- update_valid_i  in  1  update valid; always accepted, no ready.
- update_op_i  in  1  0=UPDATE, 1=FREE.
- update_addr_i  in  ADDR_W  target slot.
- update_max_i  in  WIDTH_IN  new maximum.
- update_den_i  in  WIDTH_ACC  new denominator.
- update_err_o  out  1  sticky: update or free targeted an invalid or out-of-range slot.
- free_cnt_o  out  $clog2(N_SLOTS+1)  number of invalid slots.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - All slots invalid, with max=0 and den=0.
  - rsp_valid_o=0; rsp_addr_o/rsp_max_o/rsp_den_o/rsp_err_o=0.
  - update_err_o=0; free_cnt_o=N_SLOTS.
- Request handshake:
  - Accepted when req_valid_i && req_ready_o.
  - req_ready_o = !clear_i && (!rsp_valid_o || rsp_ready_i).
  - Single registered response stage: accepted request at cycle t gives rsp_valid_o=1 at t+1.
  - Response fields hold stable until rsp_valid_o && rsp_ready_i.
  - Back-to-back throughput: 1 request per cycle when rsp_ready_i=1.
- ALLOC:
  - Picks the lowest-index invalid slot and marks it valid with max=MAX_INIT, den=0.
  - Responds with that addr, MAX_INIT, 0, err=0.
  - No free slot: err=1, addr=0, max=0, den=0; no state change.
- LOAD:
  - addr < N_SLOTS and slot valid: respond with addr, stored max/den, err=0.
  - Otherwise: err=1, addr=req_addr_i, max/den=0.
  - LOAD does not alter state.
- UPDATE: valid in-range slot gets max/den written at the clock edge. Otherwise no write and update_err_o set.
- FREE: valid in-range slot cleared to invalid. Invalid or out-of-range slot sets update_err_o.
- Same-cycle ordering: update/free is applied before the request.
  - LOAD of the address being UPDATEd returns the new values (bypass).
  - LOAD of the address being FREEd returns err=1.
  - ALLOC may select the slot being FREEd in that cycle, if it is the lowest invalid slot.
- Stalled response: update/free still apply while a response is stalled. The held response is not refreshed.
- free_cnt_o: registered; equals the count of invalid slots after all edge updates. No transient values.
- update_err_o: sticky until rst_i or clear_i.
- clear_i (synchronous):
  - All slots invalid, rsp_valid_o=0, update_err_o=0, free_cnt_o=N_SLOTS next cycle.
  - Same-cycle requests are not accepted (req_ready_o=0). Same-cycle updates are dropped.
- rst_i has priority over clear_i; reset mid-handshake discards the pending response.

Test Plan:
- Reset, then ALLOC x3 with rsp_ready_i=1 -> responses addr 0,1,2, max=16'hFF80, den=0, err=0 on consecutive cycles; free_cnt_o=5.
- UPDATE slot 1 (max=16'h3F80, den=32'h40000000), then LOAD 1 -> rsp max=16'h3F80, den=32'h40000000, err=0, one cycle after acceptance.
- Fill all 8 slots, then ALLOC -> err=1, addr=0, free_cnt_o=0. FREE slot 5 in the same cycle as the next ALLOC -> rsp addr=5, err=0, free_cnt_o=0.
- Hold rsp_ready_i=0 for 4 cycles with req_valid_i=1 -> req_ready_o=0, response fields constant; release -> next request accepted that cycle.
- UPDATE slot 3 and LOAD 3 in the same cycle -> new values returned. LOAD 9 -> err=1. FREE of an invalid slot -> update_err_o=1 and stays 1.
- clear_i during a pending response with a same-cycle ALLOC -> rsp_valid_o=0, ALLOC not accepted, free_cnt_o=8, update_err_o=0 next cycle.

Source files
------------

// File: rtl/sfm_slot_regfile.sv
// Per-row softmax state slots (running max, running denominator, valid bit).
// Updates/frees land before same-cycle requests; one registered response stage.
module sfm_slot_regfile #(
  parameter int                  N_SLOTS   = 8,
  parameter int                  ADDR_W    = 8,
  parameter int                  WIDTH_IN  = 16,
  parameter int                  WIDTH_ACC = 32,
  parameter logic [WIDTH_IN-1:0] MAX_INIT  = 16'hFF80
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_op_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ADDR_W-1:0]            rsp_addr_o,
  output logic [WIDTH_IN-1:0]          rsp_max_o,
  output logic [WIDTH_ACC-1:0]         rsp_den_o,
  output logic                         rsp_err_o,
  input  logic                         update_valid_i,
  input  logic                         update_op_i,
  input  logic [ADDR_W-1:0]            update_addr_i,
  input  logic [WIDTH_IN-1:0]          update_max_i,
  input  logic [WIDTH_ACC-1:0]         update_den_i,
  output logic                         update_err_o,
  output logic [$clog2(N_SLOTS+1)-1:0] free_cnt_o
);

  localparam int   CNT_W     = $clog2(N_SLOTS+1);
  localparam logic OP_ALLOC  = 1'b0;
  localparam logic OP_UPDATE = 1'b0;
  localparam logic OP_FREE   = 1'b1;

  logic [N_SLOTS-1:0]   r_valid;
  logic [WIDTH_IN-1:0]  r_max [N_SLOTS];
  logic [WIDTH_ACC-1:0] r_den [N_SLOTS];

  logic                 r_rsp_valid;
  logic [ADDR_W-1:0]    r_rsp_addr;
  logic [WIDTH_IN-1:0]  r_rsp_max;
  logic [WIDTH_ACC-1:0] r_rsp_den;
  logic                 r_rsp_err;
  logic                 r_upd_err;
  logic [CNT_W-1:0]     r_free_cnt;

  logic                 w_upd_slot_valid;
  logic                 w_upd_hit;
  logic                 w_upd_write;
  logic                 w_upd_free;
  logic [N_SLOTS-1:0]   w_valid_mid;
  logic [N_SLOTS-1:0]   w_valid_next;
  logic                 w_alloc_found;
  logic [ADDR_W-1:0]    w_alloc_idx;
  logic                 w_alloc_set;
  logic                 w_load_ok;
  logic [WIDTH_IN-1:0]  w_load_max;
  logic [WIDTH_ACC-1:0] w_load_den;
  logic                 w_req_fire;
  logic [ADDR_W-1:0]    w_rsp_addr;
  logic [WIDTH_IN-1:0]  w_rsp_max;
  logic [WIDTH_ACC-1:0] w_rsp_den;
  logic                 w_rsp_err;
  logic [CNT_W-1:0]     w_free_next;

  assign req_ready_o = !clear_i && (!r_rsp_valid || rsp_ready_i);
  assign w_req_fire  = req_valid_i && req_ready_o;

  always_comb begin
    w_upd_slot_valid = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (update_addr_i == ADDR_W'(i)) w_upd_slot_valid = r_valid[i];
    end
    // Out-of-range addresses never match a slot, so they count as invalid.
    w_upd_hit   = update_valid_i && !clear_i && w_upd_slot_valid;
    w_upd_write = w_upd_hit && (update_op_i == OP_UPDATE);
    w_upd_free  = w_upd_hit && (update_op_i == OP_FREE);

    w_valid_mid = r_valid;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (w_upd_free && (update_addr_i == ADDR_W'(i))) w_valid_mid[i] = 1'b0;
    end

    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    for (int i = N_SLOTS-1; i >= 0; i--) begin
      if (!w_valid_mid[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = ADDR_W'(i);
      end
    end
    w_alloc_set = w_req_fire && (req_op_i == OP_ALLOC) && w_alloc_found;

    w_load_ok  = 1'b0;
    w_load_max = '0;
    w_load_den = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (req_addr_i == ADDR_W'(i)) begin
        w_load_ok  = w_valid_mid[i];
        w_load_max = r_max[i];
        w_load_den = r_den[i];
      end
    end
    if (w_upd_write && (update_addr_i == req_addr_i)) begin
      w_load_max = update_max_i;
      w_load_den = update_den_i;
    end

    if (req_op_i == OP_ALLOC) begin
      w_rsp_addr = w_alloc_found ? w_alloc_idx : '0;
      w_rsp_max  = w_alloc_found ? MAX_INIT : '0;
      w_rsp_den  = '0;
      w_rsp_err  = !w_alloc_found;
    end else begin
      w_rsp_addr = req_addr_i;
      w_rsp_max  = w_load_ok ? w_load_max : '0;
      w_rsp_den  = w_load_ok ? w_load_den : '0;
      w_rsp_err  = !w_load_ok;
    end

    w_valid_next = w_valid_mid;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (w_alloc_set && (w_alloc_idx == ADDR_W'(i))) w_valid_next[i] = 1'b1;
    end
    if (clear_i) w_valid_next = '0;

    w_free_next = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!w_valid_next[i]) w_free_next = w_free_next + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_max[i] <= '0;
        r_den[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_next;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_upd_write && (update_addr_i == ADDR_W'(i))) begin
          r_max[i] <= update_max_i;
          r_den[i] <= update_den_i;
        end
        if (w_alloc_set && (w_alloc_idx == ADDR_W'(i))) begin
          r_max[i] <= MAX_INIT;
          r_den[i] <= '0;
        end
      end
    end
  end

  // Response fields only change on acceptance, so a stalled response stays put.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_max   <= '0;
      r_rsp_den   <= '0;
      r_rsp_err   <= 1'b0;
    end else if (clear_i) begin
      r_rsp_valid <= 1'b0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= w_rsp_addr;
      r_rsp_max   <= w_rsp_max;
      r_rsp_den   <= w_rsp_den;
      r_rsp_err   <= w_rsp_err;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_upd_err <= 1'b0;
    end else if (update_valid_i && !w_upd_hit) begin
      r_upd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_free_cnt <= CNT_W'(N_SLOTS);
    end else begin
      r_free_cnt <= w_free_next;
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_addr_o   = r_rsp_addr;
  assign rsp_max_o    = r_rsp_max;
  assign rsp_den_o    = r_rsp_den;
  assign rsp_err_o    = r_rsp_err;
  assign update_err_o = r_upd_err;
  assign free_cnt_o   = r_free_cnt;

endmodule

// File: tb/tb_sfm_slot_regfile.sv
// Scoreboard bench for sfm_slot_regfile: a slot model predicts each response
// at acceptance, and the queue front is compared while the response is held.
module tb_sfm_slot_regfile;

  localparam int N = 8;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] mx;
    logic [31:0] den;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        reqValid, reqOp, rspReady;
  logic [7:0]  reqAddr;
  logic        updValid, updOp;
  logic [7:0]  updAddr;
  logic [15:0] updMax;
  logic [31:0] updDen;

  logic        req_ready_o, rsp_valid_o, rsp_err_o, update_err_o;
  logic [7:0]  rsp_addr_o;
  logic [15:0] rsp_max_o;
  logic [31:0] rsp_den_o;
  logic [3:0]  free_cnt_o;

  int checks = 0;
  int errors = 0;

  bit          mValid [N];
  logic [15:0] mMax [N];
  logic [31:0] mDen [N];
  bit          mUpdErr;
  bit          mRspValid;
  rsp_t        expQ [$];

  always #5 clk = ~clk;

  sfm_slot_regfile dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .req_valid_i(reqValid), .req_ready_o(req_ready_o), .req_op_i(reqOp), .req_addr_i(reqAddr),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rspReady), .rsp_addr_o(rsp_addr_o),
    .rsp_max_o(rsp_max_o), .rsp_den_o(rsp_den_o), .rsp_err_o(rsp_err_o),
    .update_valid_i(updValid), .update_op_i(updOp), .update_addr_i(updAddr),
    .update_max_i(updMax), .update_den_i(updDen), .update_err_o(update_err_o),
    .free_cnt_o(free_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int freeCount();
    int n = 0;
    for (int i = 0; i < N; i++) if (!mValid[i]) n++;
    return n;
  endfunction

  // One clock: check held outputs, advance the model, then cross the edge.
  task automatic stepCycle();
    bit   expReady, fire, found;
    int   idx;
    rsp_t e;
    fire = 1'b0;
    #1;
    if (!rst) begin
      checkOutput("rsp_valid", rsp_valid_o, mRspValid);
      checkOutput("free_cnt", free_cnt_o, freeCount());
      checkOutput("update_err", update_err_o, mUpdErr);
      if (mRspValid) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_pending", 64'(expQ.size()), 64'(1));
        end else begin
          checkOutput("rsp_addr", rsp_addr_o, expQ[0].addr);
          checkOutput("rsp_max", rsp_max_o, expQ[0].mx);
          checkOutput("rsp_den", rsp_den_o, expQ[0].den);
          checkOutput("rsp_err", rsp_err_o, expQ[0].err);
          if (rspReady) void'(expQ.pop_front());
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mValid[i] = 1'b0; mMax[i] = '0; mDen[i] = '0;
      end
      mUpdErr = 1'b0;
      expQ.delete();
    end else begin
      expReady = !clr && (!mRspValid || rspReady);
      checkOutput("req_ready", req_ready_o, expReady);
      if (clr) begin
        for (int i = 0; i < N; i++) mValid[i] = 1'b0;
        mUpdErr = 1'b0;
        expQ.delete();
      end else begin
        if (updValid) begin
          if (updAddr < N && mValid[updAddr]) begin
            if (updOp == 1'b0) begin
              mMax[updAddr] = updMax;
              mDen[updAddr] = updDen;
            end else begin
              mValid[updAddr] = 1'b0;
            end
          end else begin
            mUpdErr = 1'b1;
          end
        end
        fire = reqValid && expReady;
        if (fire) begin
          if (reqOp == 1'b0) begin
            found = 1'b0; idx = 0;
            for (int i = 0; i < N; i++) begin
              if (!found && !mValid[i]) begin found = 1'b1; idx = i; end
            end
            if (found) begin
              mValid[idx] = 1'b1; mMax[idx] = 16'hFF80; mDen[idx] = '0;
              e.addr = 8'(idx); e.mx = 16'hFF80; e.den = '0; e.err = 1'b0;
            end else begin
              e.addr = '0; e.mx = '0; e.den = '0; e.err = 1'b1;
            end
          end else if (reqAddr < N && mValid[reqAddr]) begin
            e.addr = reqAddr; e.mx = mMax[reqAddr]; e.den = mDen[reqAddr]; e.err = 1'b0;
          end else begin
            e.addr = reqAddr; e.mx = '0; e.den = '0; e.err = 1'b1;
          end
          expQ.push_back(e);
        end
      end
    end
    @(posedge clk);
    if (rst || clr) mRspValid = 1'b0;
    else if (fire)  mRspValid = 1'b1;
    else if (rspReady) mRspValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit rv, input bit ro, input logic [7:0] ra,
                               input bit uv, input bit uo, input logic [7:0] ua,
                               input logic [15:0] um, input logic [31:0] ud);
    reqValid = rv; reqOp = ro; reqAddr = ra;
    updValid = uv; updOp = uo; updAddr = ua; updMax = um; updDen = ud;
    stepCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; rspReady = 1'b1;
    mRspValid = 1'b0; mUpdErr = 1'b0;
    idle(2);
    rst = 1'b0;
    checkOutput("reset_rsp_valid", rsp_valid_o, 0);
    checkOutput("reset_rsp_addr", rsp_addr_o, 0);
    checkOutput("reset_rsp_max", rsp_max_o, 0);
    checkOutput("reset_rsp_den", rsp_den_o, 0);
    checkOutput("reset_rsp_err", rsp_err_o, 0);
    checkOutput("reset_update_err", update_err_o, 0);
    checkOutput("reset_free_cnt", free_cnt_o, 8);

    $display("[TB] three allocations back to back");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("free_after_3", free_cnt_o, 5);

    $display("[TB] update slot 1 then load it");
    applyStimulus(0, 0, 0, 1, 0, 8'd1, 16'h3F80, 32'h40000000);
    applyStimulus(1, 1, 8'd1, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] fill all slots, alloc when full, free+alloc same cycle");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 8'd5, 0, 0);
    idle(1);
    checkOutput("free_full", free_cnt_o, 0);

    $display("[TB] stalled response with requests held");
    applyStimulus(1, 1, 8'd2, 0, 0, 0, 0, 0);
    rspReady = 1'b0;
    applyStimulus(1, 1, 8'd4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 8'd7, (i == 1), 0, 8'd7, 16'h1234, 32'h5678);
    rspReady = 1'b1;
    applyStimulus(1, 1, 8'd7, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] bypass, out-of-range load, sticky update error");
    applyStimulus(1, 1, 8'd3, 1, 0, 8'd3, 16'hABCD, 32'h01234567);
    applyStimulus(1, 1, 8'd9, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'd6, 1, 1, 8'd6, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 8'd6, 0, 0);
    idle(3);
    checkOutput("update_err_sticky", update_err_o, 1);
    applyStimulus(0, 0, 0, 1, 0, 8'd20, 16'h1, 32'h1);

    $display("[TB] clear during pending response");
    rspReady = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    clr = 1'b1;
    applyStimulus(1, 0, 0, 1, 0, 8'd1, 16'h7, 32'h7);
    clr = 1'b0;
    rspReady = 1'b1;
    checkOutput("clear_rsp_valid", rsp_valid_o, 0);
    checkOutput("clear_free_cnt", free_cnt_o, 8);
    checkOutput("clear_update_err", update_err_o, 0);
    idle(1);

    $display("[TB] reset mid-handshake");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    rspReady = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rspReady = 1'b1;
    checkOutput("rst_mid_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_mid_free_cnt", free_cnt_o, 8);
    idle(1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      rspReady = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      applyStimulus($urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
                    8'($urandom_range(0, 9)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 8'($urandom_range(0, 9)),
                    16'($urandom), 32'($urandom));
    end
    clr = 1'b0;
    rspReady = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
